// File: rtl/alu_pipe.sv
// alu_pipe: valid/ready ALU with 1-cycle logic/arith ops and iterative signed multiply.
// Define ALU_SAT_EN to clamp ADD/SUB/MUL results to the BW-bit signed range.
module alu_pipe #(
    parameter int BW = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [BW-1:0] in_a,
    input  logic signed [BW-1:0] in_b,
    input  logic        [2:0]    opcode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [BW:0]   out,
    output logic        [2:0]    flags,
    output logic                 busy
);
    localparam int SW = $clog2(BW);
    localparam logic [BW:0] SAT_MAX = {2'b00, {(BW-1){1'b1}}};
    localparam logic [BW:0] SAT_MIN = {2'b11, {(BW-1){1'b0}}};

    typedef enum logic {IDLE, BUSY} state_t;

    state_t          state_q, state_d;
    logic            out_valid_q, out_valid_d;
    logic [BW:0]     out_q, out_d;
    logic [2:0]      flags_q, flags_d;
    logic            done_q, done_d;
    logic [2*BW-1:0] acc_q, acc_d;
    logic [2*BW-1:0] mc_q, mc_d;
    logic [BW-1:0]   mp_q, mp_d;
    logic [SW-1:0]   cnt_q, cnt_d;

    logic            accept;
    logic            xfer;
    logic [BW:0]     a_x;
    logic [BW:0]     b_x;
    logic [BW-1:0]   lg;
    logic [BW:0]     alu_res;
    logic            alu_ovf;
    logic [2*BW-1:0] pp;
    logic            last;
    logic [BW:0]     mul_res;
    logic            mul_ovf;

    function automatic logic [2:0] mk_flags(input logic ovf, input logic [BW:0] v);
        return {ovf, v[BW], (v == '0)};
    endfunction

    assign busy      = (state_q == BUSY);
    assign in_ready  = (state_q == IDLE) && !done_q && (!out_valid_q || out_ready);
    assign out_valid = out_valid_q;
    assign out       = out_q;
    assign flags     = flags_q;
    assign accept    = in_valid && in_ready;
    assign xfer      = out_valid_q && out_ready;

    // single-cycle result for opcodes 000-110
    always_comb begin
        a_x     = {in_a[BW-1], in_a};
        b_x     = {in_b[BW-1], in_b};
        lg      = '0;
        alu_res = '0;
        alu_ovf = 1'b0;
        unique case (opcode)
            3'b000: begin
                alu_res = a_x + b_x;
                alu_ovf = alu_res[BW] ^ alu_res[BW-1];
            end
            3'b001: begin
                alu_res = a_x - b_x;
                alu_ovf = alu_res[BW] ^ alu_res[BW-1];
            end
            3'b010: lg = in_a & in_b;
            3'b011: lg = in_a | in_b;
            3'b100: lg = in_a ^ in_b;
            3'b101: lg = in_a >>> in_b[SW-1:0];
            3'b110: lg = {{(BW-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
            default: ;
        endcase
        if (opcode >= 3'b010 && opcode <= 3'b110) begin
            alu_res = {lg[BW-1], lg};
        end
`ifdef ALU_SAT_EN
        if (alu_ovf) begin
            alu_res = alu_res[BW] ? SAT_MIN : SAT_MAX;
        end
`endif
    end

    // shift-add step; the last partial product carries negative weight
    always_comb begin
        pp      = mp_q[0] ? mc_q : '0;
        last    = (cnt_q == SW'(BW - 1));
        mul_ovf = !((&acc_q[2*BW-1:BW-1]) || !(|acc_q[2*BW-1:BW-1]));
        mul_res = acc_q[BW:0];
`ifdef ALU_SAT_EN
        if (mul_ovf) begin
            mul_res = acc_q[2*BW-1] ? SAT_MIN : SAT_MAX;
        end
`endif
    end

    // next-state, multiplier datapath and output register control
    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_d       = out_q;
        flags_d     = flags_q;
        done_d      = done_q;
        acc_d       = acc_q;
        mc_d        = mc_q;
        mp_d        = mp_q;
        cnt_d       = cnt_q;
        if (xfer) begin
            out_valid_d = 1'b0;
        end
        unique case (state_q)
            IDLE: begin
                if (done_q) begin
                    out_valid_d = 1'b1;
                    out_d       = mul_res;
                    flags_d     = mk_flags(mul_ovf, mul_res);
                    done_d      = 1'b0;
                end else if (accept) begin
                    if (opcode == 3'b111) begin
                        state_d = BUSY;
                        mc_d    = {{BW{in_a[BW-1]}}, in_a};
                        mp_d    = in_b;
                        acc_d   = '0;
                        cnt_d   = '0;
                    end else begin
                        out_valid_d = 1'b1;
                        out_d       = alu_res;
                        flags_d     = mk_flags(alu_ovf, alu_res);
                    end
                end
            end
            BUSY: begin
                acc_d = last ? (acc_q - pp) : (acc_q + pp);
                mc_d  = mc_q << 1;
                mp_d  = mp_q >> 1;
                cnt_d = cnt_q + 1'b1;
                if (last) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // state and datapath registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            flags_q     <= '0;
            done_q      <= 1'b0;
            acc_q       <= '0;
            mc_q        <= '0;
            mp_q        <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            flags_q     <= flags_d;
            done_q      <= done_d;
            acc_q       <= acc_d;
            mc_q        <= mc_d;
            mp_q        <= mp_d;
            cnt_q       <= cnt_d;
        end
    end
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed vectors for alu_pipe at BW=16.
// Expected values follow ALU_SAT_EN when it is defined.
module tb_alu_pipe;
    localparam int BW = 16;

`ifdef ALU_SAT_EN
    localparam logic [16:0] ADD_EXP = 17'h07FFF;
    localparam logic [16:0] SUB_EXP = 17'h18000;
    localparam logic [16:0] MUL_EXP = 17'h18000;
    localparam logic [16:0] MXX_EXP = 17'h07FFF;
    localparam logic [16:0] MXX_FLG = 17'h4;
`else
    localparam logic [16:0] ADD_EXP = 17'h08000;
    localparam logic [16:0] SUB_EXP = 17'h17FFF;
    localparam logic [16:0] MUL_EXP = 17'h115A0;
    localparam logic [16:0] MXX_EXP = 17'h00000;
    localparam logic [16:0] MXX_FLG = 17'h5;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic [2:0]  opcode;
    logic        out_valid;
    logic        out_ready;
    logic [16:0] out;
    logic [2:0]  flags;
    logic        busy;

    int checks = 0;
    int errors = 0;

    alu_pipe #(.BW(BW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .opcode   (opcode),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out      (out),
        .flags    (flags),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [16:0] got, input logic [16:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic op1(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        in_valid = 1'b1;
        opcode   = op;
        in_a     = a;
        in_b     = b;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic mul_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic [16:0] exp, input logic [16:0] fexp);
        int n;
        op1(3'b111, a, b);
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk);
            #1 n++;
        end
        chk({tag, "_lat"}, 17'(n), 17'd17);
        chk({tag, "_out"}, out, exp);
        chk({tag, "_flg"}, 17'(flags), fexp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic seen;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        opcode    = '0;
        out_ready = 1'b1;
        #12;
        chk("rst_ov", 17'(out_valid), 17'd0);
        chk("rst_out", out, 17'd0);
        chk("rst_flg", 17'(flags), 17'd0);
        chk("rst_busy", 17'(busy), 17'd0);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        chk("rst_rdy", 17'(in_ready), 17'd1);

        op1(3'b000, 16'h7FFF, 16'h0001);
        chk("add_ov", 17'(out_valid), 17'd1);
        chk("add_out", out, ADD_EXP);
        chk("add_flg", 17'(flags), 17'h4);

        op1(3'b001, 16'h8000, 16'h0001);
        chk("sub_out", out, SUB_EXP);
        chk("sub_flg", 17'(flags), 17'h6);

        op1(3'b100, 16'h00FF, 16'h00FF);
        chk("xor_out", out, 17'd0);
        chk("xor_flg", 17'(flags), 17'h1);

        op1(3'b110, 16'hFFFB, 16'h0003);
        chk("slt_out", out, 17'd1);
        chk("slt_flg", 17'(flags), 17'h0);

        op1(3'b110, 16'h0003, 16'hFFFB);
        chk("slt0_out", out, 17'd0);

        op1(3'b010, 16'h0F0F, 16'h00FF);
        chk("and_out", out, 17'h0000F);

        op1(3'b011, 16'h8000, 16'h0001);
        chk("or_out", out, 17'h18001);
        chk("or_flg", 17'(flags), 17'h2);

        op1(3'b101, 16'hFFF0, 16'h0002);
        chk("asr_out", out, 17'h1FFFC);
        chk("asr_flg", 17'(flags), 17'h2);
        @(posedge clk);
        #1 chk("drop_ov", 17'(out_valid), 17'd0);

        op1(3'b111, 16'd300, 16'hFF38);
        in_valid = 1'b1;
        opcode   = 3'b000;
        in_a     = 16'h1234;
        in_b     = 16'h4321;
        for (int i = 0; i < 16; i++) begin
            chk("mul_busy", 17'(busy), 17'd1);
            chk("mul_rdy", 17'(in_ready), 17'd0);
            chk("mul_ov", 17'(out_valid), 17'd0);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        chk("mul_idle", 17'(busy), 17'd0);
        chk("mul_ov16", 17'(out_valid), 17'd0);
        @(posedge clk);
        #1 chk("mul_ov17", 17'(out_valid), 17'd1);
        chk("mul_out", out, MUL_EXP);
        chk("mul_flg", 17'(flags), 17'h6);

        mul_op("m76", 16'd7, 16'd6, 17'd42, 17'h0);
        mul_op("mneg", 16'hFFFD, 16'hFFFB, 17'd15, 17'h0);
        mul_op("mzero", 16'd0, 16'd123, 17'd0, 17'h1);
        mul_op("mmax", 16'h8000, 16'h8000, MXX_EXP, MXX_FLG);
        @(posedge clk);
        #1;

        out_ready = 1'b0;
        op1(3'b000, 16'd5, 16'd3);
        for (int i = 0; i < 5; i++) begin
            chk("hold_out", out, 17'd8);
            chk("hold_flg", 17'(flags), 17'h0);
            chk("hold_rdy", 17'(in_ready), 17'd0);
            chk("hold_ov", 17'(out_valid), 17'd1);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b1;
        opcode    = 3'b000;
        in_a      = 16'd1;
        in_b      = 16'd1;
        out_ready = 1'b1;
        #1 chk("b2b_rdy", 17'(in_ready), 17'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        chk("b2b_ov", 17'(out_valid), 17'd1);
        chk("b2b_out", out, 17'd2);
        @(posedge clk);
        #1 chk("b2b_drop", 17'(out_valid), 17'd0);

        op1(3'b111, 16'd300, 16'hFF38);
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ov", 17'(out_valid), 17'd0);
        chk("arst_out", out, 17'd0);
        chk("arst_flg", 17'(flags), 17'd0);
        chk("arst_busy", 17'(busy), 17'd0);
        @(negedge clk) rst_n = 1'b1;
        seen = 1'b0;
        repeat (30) begin
            @(posedge clk);
            #1 if (out_valid) seen = 1'b1;
        end
        chk("arst_nores", 17'(seen), 17'd0);
        chk("arst_rdy", 17'(in_ready), 17'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
